// File: rtl/ram_arbiter_rr.sv
// N-port arbiter sharing one single-ported RAM: round-robin or fixed priority grant,
// sub-word lane steering and a fixed-latency response pipeline back to the granted port.
module ram_arbiter_rr #(
    parameter int NPORTS     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_WIDTH  = 32,
    parameter int PORT_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int PRIO_MODE  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NPORTS-1:0]              port_req_i,
    output logic [NPORTS-1:0]              port_gnt_o,
    output logic [NPORTS-1:0]              port_rvalid_o,
    input  logic [NPORTS*ADDR_WIDTH-1:0]   port_addr_i,
    input  logic [NPORTS-1:0]              port_we_i,
    input  logic [NPORTS*PORT_WIDTH/8-1:0] port_be_i,
    input  logic [NPORTS*PORT_WIDTH-1:0]   port_wdata_i,
    output logic [NPORTS*PORT_WIDTH-1:0]   port_rdata_o,
    output logic                           ram_en_o,
    output logic [ADDR_WIDTH-1:0]          ram_addr_o,
    output logic                           ram_we_o,
    output logic [RAM_WIDTH/8-1:0]         ram_be_o,
    output logic [RAM_WIDTH-1:0]           ram_wdata_o,
    input  logic [RAM_WIDTH-1:0]           ram_rdata_i
);
    localparam int IW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int LANES = RAM_WIDTH / PORT_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PB    = PORT_WIDTH / 8;
    localparam int LSB   = $clog2(PB);

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gidx;
    logic                  any;
    int                    cand;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [PB-1:0]         be_sel;
    logic [PORT_WIDTH-1:0] wd_sel;
    logic [LW-1:0]         lane;

    // Scan order starts just after the last winner (RR) or at port 0 (fixed).
    always_comb begin
        gidx = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NPORTS; i++) begin
            if (PRIO_MODE != 0) cand = i;
            else                cand = (int'(ptr) + 1 + i) % NPORTS;
            if (!any && port_req_i[IW'(cand)]) begin
                any  = 1'b1;
                gidx = IW'(cand);
            end
        end
    end

    always_comb begin
        port_gnt_o = '0;
        if (any) port_gnt_o[gidx] = 1'b1;
    end

    assign addr_sel = port_addr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_sel   = port_be_i[int'(gidx)*PB +: PB];
    assign wd_sel   = port_wdata_i[int'(gidx)*PORT_WIDTH +: PORT_WIDTH];

    generate
        if (LANES > 1) begin : g_lane
            assign lane = addr_sel[LSB +: LW];
        end else begin : g_nolane
            assign lane = '0;
        end
    endgenerate

    assign ram_en_o    = any;
    assign ram_addr_o  = any ? addr_sel : '0;
    assign ram_we_o    = any & port_we_i[gidx];
    assign ram_wdata_o = any ? {LANES{wd_sel}} : '0;

    always_comb begin
        ram_be_o = '0;
        if (any) ram_be_o[int'(lane)*PB +: PB] = be_sel;
    end

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [IW-1:0]         idx_pipe  [RD_LATENCY];
    logic [LW-1:0]         lane_pipe [RD_LATENCY];

    // Writes also travel the pipeline so every grant gets exactly one rvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IW'(NPORTS - 1);
            vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                idx_pipe[k]  <= '0;
                lane_pipe[k] <= '0;
            end
        end else begin
            if (any) ptr <= gidx;
            vld_pipe[0]  <= any;
            idx_pipe[0]  <= gidx;
            lane_pipe[0] <= lane;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                idx_pipe[k]  <= idx_pipe[k-1];
                lane_pipe[k] <= lane_pipe[k-1];
            end
        end
    end

    logic                  vld_out;
    logic [IW-1:0]         idx_out;
    logic [LW-1:0]         lane_out;
    logic [PORT_WIDTH-1:0] rlane;

    assign vld_out  = vld_pipe[RD_LATENCY-1];
    assign idx_out  = idx_pipe[RD_LATENCY-1];
    assign lane_out = lane_pipe[RD_LATENCY-1];
    assign rlane    = ram_rdata_i[int'(lane_out)*PORT_WIDTH +: PORT_WIDTH];

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_rsp
            assign port_rvalid_o[p] = vld_out && (idx_out == IW'(p));
            assign port_rdata_o[p*PORT_WIDTH +: PORT_WIDTH] = port_rvalid_o[p] ? rlane : '0;
        end
    endgenerate
endmodule
